spi_input_conditioner: RTL and testbench



---
 rtl/spi_input_conditioner_pkg.sv | 18 +
 rtl/spi_input_conditioner_if.sv | 43 ++++
 rtl/spi_input_conditioner_ch.sv | 67 ++++++
 rtl/spi_input_conditioner.sv | 59 +++++
 tb/tb_spi_input_conditioner.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_input_conditioner_pkg.sv
// Shared constants for the SPI input conditioning front end and its neighbours.
package spi_pkg;

    // Default debounce settings: a change must persist WAIT_TIME cycles past sync.
    localparam int DEFAULT_WAIT_TIME     = 3;
    localparam int DEFAULT_COUNTER_WIDTH = 3;

    // Idle / reset level of each SPI pin (CS is active low, so idles high).
    localparam logic MOSI_IDLE = 1'b0;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;

    // True when a counter of the given width can reach the wait count.
    function automatic bit counter_fits(input int wait_time, input int counter_width);
        return (64'(1) << counter_width) > 64'(wait_time);
    endfunction

endpackage

// File: rtl/spi_input_conditioner_if.sv
// Pin-side and conditioned-side signals of the SPI input conditioner.
// The master drives the raw pins and observes the conditioned levels/strobes;
// the slave (the conditioner) does the reverse. Debounce counters are exposed
// read-only so the in-flight debounce state is observable.
interface spi_input_conditioner_if
    import spi_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
);
    logic                     mosi_pin;
    logic                     sclk_pin;
    logic                     cs_pin;

    logic                     mosi_cond;
    logic                     mosi_posedge;
    logic                     mosi_negedge;
    logic                     sclk_cond;
    logic                     sclk_posedge;
    logic                     sclk_negedge;
    logic                     cs_cond;
    logic                     cs_posedge;
    logic                     cs_negedge;

    logic [COUNTER_WIDTH-1:0] mosi_cnt;
    logic [COUNTER_WIDTH-1:0] sclk_cnt;
    logic [COUNTER_WIDTH-1:0] cs_cnt;

    modport master (
        output mosi_pin, sclk_pin, cs_pin,
        input  mosi_cond, mosi_posedge, mosi_negedge,
        input  sclk_cond, sclk_posedge, sclk_negedge,
        input  cs_cond, cs_posedge, cs_negedge,
        input  mosi_cnt, sclk_cnt, cs_cnt
    );

    modport slave (
        input  mosi_pin, sclk_pin, cs_pin,
        output mosi_cond, mosi_posedge, mosi_negedge,
        output sclk_cond, sclk_posedge, sclk_negedge,
        output cs_cond, cs_posedge, cs_negedge,
        output mosi_cnt, sclk_cnt, cs_cnt
    );
endinterface

// File: rtl/spi_input_conditioner_ch.sv
// One conditioning channel: two-flop synchronizer, debounce counter and
// registered edge strobes. A change on the synchronized pin is accepted only
// after it has disagreed with the conditioned level for WAIT_TIME+1 checks.
module input_conditioner_ch
    import spi_pkg::*;
#(
    parameter int   WAIT_TIME     = DEFAULT_WAIT_TIME,
    parameter int   COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_pin,
    output logic                     o_cond,
    output logic                     o_posedge,
    output logic                     o_negedge,
    output logic [COUNTER_WIDTH-1:0] o_cnt
);

    // Refuse to build a counter that can never reach the wait count.
    if (!counter_fits(WAIT_TIME, COUNTER_WIDTH)) begin : g_bad_width
        $error("input_conditioner_ch: COUNTER_WIDTH too small for WAIT_TIME");
    end

    localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    logic                     r_sync0;
    logic                     r_sync1;
    logic                     r_cond;
    logic                     r_posedge;
    logic                     r_negedge;
    logic [COUNTER_WIDTH-1:0] r_cnt;

    // Synchronize, debounce and emit a one-cycle strobe when a change is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0   <= RESET_VAL;
            r_sync1   <= RESET_VAL;
            r_cond    <= RESET_VAL;
            r_cnt     <= '0;
            r_posedge <= 1'b0;
            r_negedge <= 1'b0;
        end else begin
            r_sync0   <= i_pin;
            r_sync1   <= r_sync0;
            r_posedge <= 1'b0;
            r_negedge <= 1'b0;
            if (r_sync1 == r_cond) begin
                r_cnt <= '0;
            end else if (r_cnt == WAIT_CNT) begin
                r_cond    <= r_sync1;
                r_cnt     <= '0;
                r_posedge <= r_sync1;
                r_negedge <= ~r_sync1;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_cond    = r_cond;
    assign o_posedge = r_posedge;
    assign o_negedge = r_negedge;
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/spi_input_conditioner.sv
// SPI pin front end: three independent conditioning channels (MOSI, SCLK, CS)
// turning raw asynchronous pins into clean levels and edge strobes.
module spi_input_conditioner
    import spi_pkg::*;
#(
    parameter int WAIT_TIME     = DEFAULT_WAIT_TIME,
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    spi_input_conditioner_if.slave   bus
);

    // MOSI data line, idles low.
    input_conditioner_ch #(
        .WAIT_TIME     (WAIT_TIME),
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .RESET_VAL     (MOSI_IDLE)
    ) u_mosi (
        .clk       (clk),
        .reset     (reset),
        .i_pin     (bus.mosi_pin),
        .o_cond    (bus.mosi_cond),
        .o_posedge (bus.mosi_posedge),
        .o_negedge (bus.mosi_negedge),
        .o_cnt     (bus.mosi_cnt)
    );

    // SCLK, idles low; its strobes drive sampling and shifting downstream.
    input_conditioner_ch #(
        .WAIT_TIME     (WAIT_TIME),
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .RESET_VAL     (SCLK_IDLE)
    ) u_sclk (
        .clk       (clk),
        .reset     (reset),
        .i_pin     (bus.sclk_pin),
        .o_cond    (bus.sclk_cond),
        .o_posedge (bus.sclk_posedge),
        .o_negedge (bus.sclk_negedge),
        .o_cnt     (bus.sclk_cnt)
    );

    // Chip select, active low, idles high.
    input_conditioner_ch #(
        .WAIT_TIME     (WAIT_TIME),
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .RESET_VAL     (CS_IDLE)
    ) u_cs (
        .clk       (clk),
        .reset     (reset),
        .i_pin     (bus.cs_pin),
        .o_cond    (bus.cs_cond),
        .o_posedge (bus.cs_posedge),
        .o_negedge (bus.cs_negedge),
        .o_cnt     (bus.cs_cnt)
    );

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Directed bench for spi_input_conditioner with default parameters.
// Latency convention: pin set before edge k (the capture edge); the strobe is
// visible just after edge k+5, i.e. after the 6th step counted from the change.
module tb_spi_input_conditioner;

    localparam int LAT = 6;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    spi_input_conditioner_if #(.COUNTER_WIDTH(3)) bus ();

    spi_input_conditioner #(
        .WAIT_TIME     (3),
        .COUNTER_WIDTH (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One clock edge, then settle so registered outputs can be sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        int sclk_lat;
        int mosi_lat;
        int cs_seen;
        reset = 1'b1;
        bus.mosi_pin = 1'b1;
        bus.sclk_pin = 1'b1;
        bus.cs_pin   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.cs_cond, bus.sclk_cond, bus.mosi_cond} !== 3'b100) begin
                errors++;
                $display("FAIL reset_levels: got cs/sclk/mosi=%b required 100",
                         {bus.cs_cond, bus.sclk_cond, bus.mosi_cond});
            end
            checks++;
            if ({bus.mosi_posedge, bus.mosi_negedge, bus.sclk_posedge, bus.sclk_negedge,
                 bus.cs_posedge, bus.cs_negedge} !== 6'b0) begin
                errors++;
                $display("FAIL reset_strobes: got %b required 000000",
                         {bus.mosi_posedge, bus.mosi_negedge, bus.sclk_posedge,
                          bus.sclk_negedge, bus.cs_posedge, bus.cs_negedge});
            end
        end
        reset = 1'b0;
        sclk_lat = 0;
        mosi_lat = 0;
        cs_seen  = 0;
        for (int s = 1; s <= 10; s++) begin
            step();
            if (bus.sclk_posedge && sclk_lat == 0) sclk_lat = s;
            if (bus.mosi_posedge && mosi_lat == 0) mosi_lat = s;
            if (bus.cs_posedge || bus.cs_negedge) cs_seen++;
        end
        checks++;
        if (sclk_lat !== LAT) begin
            errors++;
            $display("FAIL release_sclk_lat: got %0d required %0d", sclk_lat, LAT);
        end
        checks++;
        if (mosi_lat !== LAT) begin
            errors++;
            $display("FAIL release_mosi_lat: got %0d required %0d", mosi_lat, LAT);
        end
        checks++;
        if (cs_seen !== 0) begin
            errors++;
            $display("FAIL release_cs_strobe: got %0d required 0", cs_seen);
        end
    endtask

    task automatic test_clean_edge();
        int first;
        int pos_cnt;
        int neg_cnt;
        bus.sclk_pin = 1'b0;
        bus.mosi_pin = 1'b0;
        idle(12);
        bus.sclk_pin = 1'b1;
        first = 0;
        pos_cnt = 0;
        neg_cnt = 0;
        for (int s = 1; s <= 10; s++) begin
            step();
            if (s == LAT - 1) begin
                checks++;
                if (bus.sclk_cond !== 1'b0) begin
                    errors++;
                    $display("FAIL clean_early_cond: got %b required 0", bus.sclk_cond);
                end
            end
            if (bus.sclk_posedge) begin
                pos_cnt++;
                if (first == 0) first = s;
            end
            if (bus.sclk_negedge) neg_cnt++;
        end
        checks++;
        if (pos_cnt !== 1) begin
            errors++;
            $display("FAIL clean_pos_count: got %0d required 1", pos_cnt);
        end
        checks++;
        if (first !== LAT) begin
            errors++;
            $display("FAIL clean_pos_lat: got %0d required %0d", first, LAT);
        end
        checks++;
        if (neg_cnt !== 0) begin
            errors++;
            $display("FAIL clean_neg_count: got %0d required 0", neg_cnt);
        end
        checks++;
        if (bus.sclk_cond !== 1'b1) begin
            errors++;
            $display("FAIL clean_cond: got %b required 1", bus.sclk_cond);
        end
    endtask

    task automatic test_glitch();
        int strobes;
        int cond_high;
        int pos_at;
        int neg_at;
        int pos_cnt;
        int neg_cnt;
        // 3-cycle pulse: must vanish
        bus.mosi_pin = 1'b1;
        strobes = 0;
        cond_high = 0;
        for (int s = 1; s <= 15; s++) begin
            if (s == 4) bus.mosi_pin = 1'b0;
            step();
            if (bus.mosi_posedge || bus.mosi_negedge) strobes++;
            if (bus.mosi_cond) cond_high++;
        end
        checks++;
        if (strobes !== 0) begin
            errors++;
            $display("FAIL glitch3_strobes: got %0d required 0", strobes);
        end
        checks++;
        if (cond_high !== 0) begin
            errors++;
            $display("FAIL glitch3_cond: got %0d high cycles required 0", cond_high);
        end
        // 6-cycle pulse: accepted both ways, 6 cycles apart
        bus.mosi_pin = 1'b1;
        pos_at = 0;
        neg_at = 0;
        pos_cnt = 0;
        neg_cnt = 0;
        for (int s = 1; s <= 20; s++) begin
            if (s == 7) bus.mosi_pin = 1'b0;
            step();
            if (bus.mosi_posedge) begin
                pos_cnt++;
                pos_at = s;
            end
            if (bus.mosi_negedge) begin
                neg_cnt++;
                neg_at = s;
            end
        end
        checks++;
        if (pos_cnt !== 1 || neg_cnt !== 1) begin
            errors++;
            $display("FAIL pulse6_counts: got pos=%0d neg=%0d required 1/1", pos_cnt, neg_cnt);
        end
        checks++;
        if (pos_at !== LAT || neg_at !== LAT + 6) begin
            errors++;
            $display("FAIL pulse6_timing: got pos@%0d neg@%0d required %0d/%0d",
                     pos_at, neg_at, LAT, LAT + 6);
        end
    endtask

    task automatic test_bounce();
        int neg_cnt;
        int neg_at;
        int pos_cnt;
        bus.cs_pin = 1'b1;
        step();
        bus.cs_pin = 1'b0;
        step();
        bus.cs_pin = 1'b1;
        step();
        bus.cs_pin = 1'b0;
        neg_cnt = 0;
        neg_at = 0;
        pos_cnt = 0;
        for (int s = 1; s <= 15; s++) begin
            step();
            if (bus.cs_negedge) begin
                neg_cnt++;
                if (neg_at == 0) neg_at = s;
            end
            if (bus.cs_posedge) pos_cnt++;
        end
        checks++;
        if (neg_cnt !== 1 || pos_cnt !== 0) begin
            errors++;
            $display("FAIL bounce_counts: got neg=%0d pos=%0d required 1/0", neg_cnt, pos_cnt);
        end
        checks++;
        if (neg_at !== LAT) begin
            errors++;
            $display("FAIL bounce_lat: got %0d required %0d", neg_at, LAT);
        end
        checks++;
        if (bus.cs_cond !== 1'b0) begin
            errors++;
            $display("FAIL bounce_cond: got %b required 0", bus.cs_cond);
        end
    endtask

    task automatic test_transaction();
        int pos_cnt;
        int neg_cnt;
        int cs_neg;
        int last;
        int t;
        // return to idle first
        bus.cs_pin   = 1'b1;
        bus.sclk_pin = 1'b0;
        idle(12);
        bus.cs_pin = 1'b0;
        pos_cnt = 0;
        neg_cnt = 0;
        cs_neg  = 0;
        last    = 0;
        t       = 0;
        for (int p = 0; p < 16; p++) begin
            for (int h = 0; h < 20; h++) begin
                bus.sclk_pin = (h < 10);
                step();
                t++;
                if (bus.cs_negedge) cs_neg++;
                if (bus.sclk_posedge || bus.sclk_negedge) begin
                    if (bus.sclk_posedge) pos_cnt++;
                    if (bus.sclk_negedge) neg_cnt++;
                    if (last != 0) begin
                        checks++;
                        if (t - last !== 10) begin
                            errors++;
                            $display("FAIL txn_spacing: got %0d required 10 at step %0d",
                                     t - last, t);
                        end
                    end
                    last = t;
                end
            end
        end
        checks++;
        if (pos_cnt !== 16 || neg_cnt !== 16) begin
            errors++;
            $display("FAIL txn_sclk_counts: got pos=%0d neg=%0d required 16/16", pos_cnt, neg_cnt);
        end
        checks++;
        if (cs_neg !== 1) begin
            errors++;
            $display("FAIL txn_cs_neg: got %0d required 1", cs_neg);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int reached;
        int strobes;
        bus.sclk_pin = 1'b1;
        reached = 0;
        for (int s = 1; s <= 10; s++) begin
            step();
            if (bus.sclk_cnt == 3'd2) begin
                reached = s;
                break;
            end
        end
        checks++;
        if (reached !== 4) begin
            errors++;
            $display("FAIL mid_cnt_reach: got step %0d required 4", reached);
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus.sclk_cnt !== 3'd0 || bus.sclk_cond !== 1'b0 || bus.sclk_posedge !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: got cnt=%0d cond=%b pos=%b required 0/0/0",
                     bus.sclk_cnt, bus.sclk_cond, bus.sclk_posedge);
        end
        step();
        bus.sclk_pin = 1'b0;
        reset = 1'b0;
        strobes = 0;
        for (int s = 1; s <= 10; s++) begin
            step();
            if (bus.sclk_posedge || bus.sclk_negedge) strobes++;
        end
        checks++;
        if (strobes !== 0 || bus.sclk_cond !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_release: got strobes=%0d cond=%b required 0/0",
                     strobes, bus.sclk_cond);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.mosi_pin = 1'b0;
        bus.sclk_pin = 1'b0;
        bus.cs_pin   = 1'b1;
        test_reset();
        test_clean_edge();
        test_glitch();
        test_bounce();
        test_transaction();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
